// File: rtl/bit_lsr_pkg.sv
// Shared ALU datapath types: operand word and shift-amount widths.
package bit_lsr_pkg;

  localparam int WIDTH = 32;
  localparam int SHW   = 5;

  typedef logic [WIDTH-1:0] word_t;
  typedef logic [SHW-1:0]   shamt_t;

endpackage : bit_lsr_pkg

// File: rtl/bit_lsr_stage.sv
// One barrel-network stage: logical right shift by a fixed DIST when sel is set.
module lsr_stage #(
  parameter int DIST = 1
) (
  input  logic [31:0] din,
  input  logic        sel,
  output logic [31:0] dout
);
  import bit_lsr_pkg::*;

  word_t shifted;

  assign shifted = {{DIST{1'b0}}, din[WIDTH-1:DIST]};
  assign dout    = sel ? shifted : din;

endmodule : lsr_stage

// File: rtl/bit_lsr.sv
// Registered 32-bit logical shift-right: 5-stage barrel network feeding one output register.
module bit_lsr #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] Rin,
  input  logic [SHW-1:0]   n,
  output logic [WIDTH-1:0] Rx,
  output logic             out_valid
);
  import bit_lsr_pkg::*;

  // p0: combinational barrel network, distances 1,2,4,8,16 in order of n bits
  logic [SHW:0][WIDTH-1:0] stg_p0;
  logic [WIDTH-1:0]        rx_p1;
  logic                    vld_p1;

  assign stg_p0[0] = Rin;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    lsr_stage #(
      .DIST(1 << k)
    ) u_stage (
      .din (stg_p0[k]),
      .sel (n[k]),
      .dout(stg_p0[k+1])
    );
  end

  // p1: output register; the result holds while no new operand arrives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_p1  <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        rx_p1 <= stg_p0[SHW];
      end
    end
  end

  assign Rx        = rx_p1;
  assign out_valid = vld_p1;

endmodule : bit_lsr

// File: tb/tb_bit_lsr.sv
// Self-checking bench for bit_lsr: directed cases plus randomized traffic vs. a reference model.
module tb_bit_lsr;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] Rin;
  logic [4:0]  n;
  logic [31:0] Rx;
  logic        out_valid;

  int tests_run;
  int tests_failed;

  // reference model state
  logic [31:0] exp_rx;
  logic        exp_vld;

  bit_lsr #(
    .WIDTH(32),
    .SHW  (5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .Rin      (Rin),
    .n        (n),
    .Rx       (Rx),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, want);
    end
  endtask

  // logical right shift as unsigned division by 2**sh
  function automatic logic [31:0] ref_lsr(input logic [31:0] v, input int sh);
    longint unsigned q;
    q = longint'(v) / (64'd1 << sh);
    return q[31:0];
  endfunction

  task automatic step(input string tag, input logic [31:0] rin_v, input logic [4:0] n_v, input logic v);
    @(negedge clk);
    Rin      = rin_v;
    n        = n_v;
    in_valid = v;
    @(posedge clk);
    #1;
    if (v) exp_rx = ref_lsr(rin_v, int'(n_v));
    exp_vld = v;
    check_eq({tag, ".rx"}, Rx, exp_rx);
    check_eq({tag, ".vld"}, {31'd0, out_valid}, {31'd0, exp_vld});
  endtask

  initial begin
    #1ms;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] held;
    tests_run    = 0;
    tests_failed = 0;
    exp_rx       = '0;
    exp_vld      = 1'b0;
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    Rin          = '0;
    n            = '0;

    repeat (2) @(posedge clk);
    #1;
    check_eq("por.rx", Rx, 32'h0);
    check_eq("por.vld", {31'd0, out_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    step("idle0", 32'h1234_5678, 5'd3, 1'b0);
    check_eq("idle0.rx0", Rx, 32'h0);

    // directed cases
    step("mixed", 32'hE0FF_C003, 5'd12, 1'b1);
    check_eq("mixed.lit", Rx, 32'h000E_0FFC);
    step("b2b0", 32'd924385, 5'd5, 1'b1);
    check_eq("b2b0.lit", Rx, 32'd28887);
    step("b2b1", 32'd3, 5'd1, 1'b1);
    check_eq("b2b1.lit", Rx, 32'd1);
    step("b2b2", 32'd2147483648, 5'd25, 1'b1);
    check_eq("b2b2.lit", Rx, 32'd64);
    step("zero", 32'd15, 5'd0, 1'b1);
    check_eq("zero.lit", Rx, 32'd15);
    step("nosx31", 32'hFFFF_FFFF, 5'd31, 1'b1);
    check_eq("nosx31.lit", Rx, 32'h0000_0001);
    step("nosx1", 32'h8000_0000, 5'd1, 1'b1);
    check_eq("nosx1.lit", Rx, 32'h4000_0000);

    // hold: idle cycles with changing operands must not disturb Rx
    step("cap", 32'hA5A5_F00D, 5'd4, 1'b1);
    held = Rx;
    for (int i = 0; i < 3; i++) begin
      step("hold", $urandom, 5'($urandom_range(0, 31)), 1'b0);
      check_eq("hold.same", Rx, held);
    end

    // every single shift amount on a random operand
    for (int s = 0; s < 32; s++) begin
      step("sweep", $urandom | 32'h8000_0001, 5'(s), 1'b1);
    end

    // randomized traffic with random valid gaps
    for (int i = 0; i < 300; i++) begin
      step("rand", $urandom, 5'($urandom_range(0, 31)), ($urandom_range(0, 3) != 0));
    end

    // asynchronous reset mid-cycle with a nonzero result held
    step("prerst", 32'hDEAD_BEEF, 5'd0, 1'b1);
    #2;
    Rin      = 32'hFFFF_0000;
    n        = 5'd2;
    in_valid = 1'b1;
    rst_n    = 1'b0;
    #1;
    exp_rx  = '0;
    exp_vld = 1'b0;
    check_eq("arst.rx", Rx, 32'h0);
    check_eq("arst.vld", {31'd0, out_valid}, 32'h0);
    @(posedge clk);
    #1;
    check_eq("arst.hold.rx", Rx, 32'h0);
    check_eq("arst.hold.vld", {31'd0, out_valid}, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    step("postrst.idle", 32'h7777_7777, 5'd1, 1'b0);
    check_eq("postrst.idle.rx0", Rx, 32'h0);
    step("postrst.cap", 32'h7777_7777, 5'd1, 1'b1);
    check_eq("postrst.cap.lit", Rx, 32'h3BBB_BBBB);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_bit_lsr

// File: doc/bit_lsr.md
# bit_lsr

Registered 32-bit logical shift-right unit for the 32-bit ALU datapath. It shifts a 32-bit operand right by 0–31 positions, zero-filling from the MSB. The result is captured in an output register with one cycle of latency. It sits beside the ALU's other shift and logic units, and the ALU result mux selects its output.

## Interface
Parameters:
- `WIDTH`, default 32: operand width. Only 32 is supported.
- `SHW`, default 5: shift-amount width, equal to log2(`WIDTH`).

Ports:
- `clk`, in, 1: the single clock. All state changes on its rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `in_valid`, in, 1: when high, `Rin` and `n` are captured this cycle.
- `Rin`, in, 32: operand, treated as unsigned.
- `n`, in, 5: shift amount, 0–31.
- `Rx`, out, 32: registered result, equal to `Rin >> n` (logical).
- `out_valid`, out, 1: high for one cycle when `Rx` holds a new result.

## Operation
- Result bit i equals `Rin[i+n]` when i+n ≤ 31; otherwise it is 0.
- The shift is logical. Bit 31 is never replicated.
- Implemented as a 5-stage barrel network. Stage k shifts by 2^k when `n[k]` is 1 and passes the data through when `n[k]` is 0. The stages are ordered k = 0..4.
- `n = 0` passes `Rin` through unchanged.
- `n = 31` leaves only the old `Rin[31]`, placed in `Rx[0]`.
- There is no out-of-range case, because `n` is 5 bits wide.
- There is no carry or overflow output and no flags.

## Timing
- The barrel network is purely combinational from `Rin` and `n` to the register D input.
- On each rising edge of `clk` with `in_valid = 1`:
  - `Rx` is loaded with the shifted value.
  - `out_valid` is set to 1.
- On each rising edge with `in_valid = 0`:
  - `Rx` holds its previous value.
  - `out_valid` is set to 0.
- Latency is exactly 1 cycle. Throughput is 1 result per cycle.
- There is no backpressure. Back-to-back valid inputs produce back-to-back results.
- Reset:
  - `rst_n` low clears `Rx` to 0 and `out_valid` to 0 immediately, without waiting for a clock edge.
  - Both outputs stay cleared while `rst_n` is low.
  - An input presented in the cycle that reset asserts is discarded.
  - The first capture happens on the first rising edge after `rst_n` deasserts with `in_valid = 1`.
- `Rin` and `n` may change every cycle. Only the values present at the capturing edge matter.

## Structure
- Shared ALU package holds:
  - `WIDTH = 32` and `SHW = 5`.
  - A `word_t` typedef (32 bits) and a `shamt_t` typedef (5 bits).
- One sub-module, `lsr_stage`:
  - Parameter `DIST`; ports: data in, select bit, data out.
  - Output is `{DIST zeros, din[WIDTH-1:DIST]}` when select is 1, otherwise `din`.
- The top level instantiates 5 `lsr_stage` instances with `DIST` = 1, 2, 4, 8, 16, followed by the output register and the valid flop.

## Test plan
- Reset:
  - Assert `rst_n = 0` mid-cycle, with `Rx` previously nonzero.
  - Required: `Rx = 0` and `out_valid = 0` before the next clock edge.
  - Required: both stay 0 until valid input is presented after reset deasserts.
- Mixed pattern:
  - `Rin = 0xE0FFC003`, `n = 12`, `in_valid = 1`.
  - Required: one cycle later, `Rx = 0x000E0FFC` and `out_valid = 1`.
- Back-to-back inputs on consecutive cycles:
  - Apply (`Rin = 924385`, `n = 5`), then (`Rin = 3`, `n = 1`), then (`Rin = 2147483648`, `n = 25`).
  - Required: `Rx` = 28887, then 1, then 64, on consecutive cycles.
  - Required: `out_valid` stays high throughout.
- Zero shift:
  - `Rin = 15`, `n = 0`.
  - Required: `Rx = 15`.
- No sign extension:
  - `Rin = 0xFFFFFFFF`, `n = 31`.
  - Required: `Rx = 0x00000001`.
  - Then `Rin = 0x80000000`, `n = 1`.
  - Required: `Rx = 0x40000000`.
- Hold:
  - Capture a result, then drive `in_valid = 0` with changing `Rin` and `n` for 3 cycles.
  - Required: `Rx` is unchanged.
  - Required: `out_valid` is 0 from the first idle edge onward.
